// File: rtl/bru_pkg.sv
// Branch resolve unit shared types and constants.
// Slot bundle and B-type immediate helper used by the EX-stage resolver.
package bru_pkg;

    localparam int BRU_XLEN = 32;

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef struct packed {
        logic                valid;
        logic [BRU_XLEN-1:0] pc;
        logic [31:0]         inst;
        logic                predict;
    } bslot_t;

    function automatic logic [31:0] b_imm(input logic [31:0] inst);
        return {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
    endfunction

endpackage

// File: rtl/branch_resolve_unit_cond.sv
// Branch condition evaluator: funct3 plus operands to {is_valid_f3, cond}.
// Purely combinational.
module branch_cond_eval
    import bru_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            is_valid_f3,
    output logic            cond
);

    logic eq;
    logic lt;
    logic ltu;

    assign eq  = (a == b);
    assign lt  = ($signed(a) < $signed(b));
    assign ltu = (a < b);

    always_comb begin
        is_valid_f3 = 1'b0;
        cond        = 1'b0;
        unique case (funct3)
            F3_BEQ:  begin is_valid_f3 = 1'b1; cond = eq;   end
            F3_BNE:  begin is_valid_f3 = 1'b1; cond = !eq;  end
            F3_BLT:  begin is_valid_f3 = 1'b1; cond = lt;   end
            F3_BGE:  begin is_valid_f3 = 1'b1; cond = !lt;  end
            F3_BLTU: begin is_valid_f3 = 1'b1; cond = ltu;  end
            F3_BGEU: begin is_valid_f3 = 1'b1; cond = !ltu; end
            default: begin is_valid_f3 = 1'b0; cond = 1'b0; end
        endcase
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolver: ID/EX prediction slots, mispredict flush, redirect PC.
// Optional BRU_STATS_EN adds saturating branch / mispredict counters.
module branch_resolve_unit
    import bru_pkg::*;
#(
    parameter int XLEN = BRU_XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_valid,
    input  logic [XLEN-1:0] if_pc,
    input  logic [31:0]     if_inst,
    input  logic            if_predict,
    input  logic            stall,
    input  logic [XLEN-1:0] ex_rs1_data,
    input  logic [XLEN-1:0] ex_rs2_data,
`ifdef BRU_STATS_EN
    output logic [XLEN-1:0] stat_branches,
    output logic [XLEN-1:0] stat_mispredicts,
`endif
    output logic            b_check,
    output logic            b_take,
    output logic            flush,
    output logic [XLEN-1:0] redirect_pc
);

    bslot_t id_q;
    bslot_t ex_q;

    logic            f3_ok;
    logic            cond;
    logic            is_branch;
    logic [XLEN-1:0] imm_x;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] seq_pc;
    logic            unused_inst;

    // Flush outranks stall so wrong-path work never survives a hold.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            id_q <= '0;
            ex_q <= '0;
        end else if (flush) begin
            id_q.valid <= 1'b0;
            ex_q.valid <= 1'b0;
        end else if (stall) begin
            ex_q.valid <= 1'b0;
        end else begin
            id_q <= '{valid: if_valid, pc: if_pc,
                      inst: if_inst, predict: if_predict};
            ex_q <= id_q;
        end
    end

    branch_cond_eval #(
        .XLEN(XLEN)
    ) u_cond (
        .funct3      (ex_q.inst[14:12]),
        .a           (ex_rs1_data),
        .b           (ex_rs2_data),
        .is_valid_f3 (f3_ok),
        .cond        (cond)
    );

    assign is_branch = (ex_q.inst[6:0] == OPC_BRANCH) && f3_ok;
    assign b_check   = ex_q.valid && is_branch;
    assign b_take    = b_check && cond;
    assign flush     = b_check && (b_take != ex_q.predict);

    assign imm_x     = XLEN'($signed(b_imm(ex_q.inst)));
    assign target    = ex_q.pc + imm_x;
    assign seq_pc    = ex_q.pc + XLEN'(4);

    assign redirect_pc = flush ? (b_take ? target : seq_pc) : '0;

    assign unused_inst = ^ex_q.inst[24:15];

`ifdef BRU_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_branches    <= '0;
            stat_mispredicts <= '0;
        end else begin
            if (b_check && (stat_branches != '1))
                stat_branches <= stat_branches + XLEN'(1);
            if (flush && (stat_mispredicts != '1))
                stat_mispredicts <= stat_mispredicts + XLEN'(1);
        end
    end
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed + randomized bench for branch_resolve_unit.
// Reference model derives outcomes from branch rules with plain arithmetic.
module tb_branch_resolve_unit;

    logic        clk;
    logic        rst;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_predict;
    logic        stall;
    logic [31:0] ex_rs1_data;
    logic [31:0] ex_rs2_data;
    logic        b_check;
    logic        b_take;
    logic        flush;
    logic [31:0] redirect_pc;
`ifdef BRU_STATS_EN
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;
`endif

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        bit          v;
        logic [31:0] pc;
        logic [31:0] inst;
        bit          p;
    } rec_t;

    rec_t pl[$];

    branch_resolve_unit #(.XLEN(32)) dut (
        .clk              (clk),
        .rst              (rst),
        .if_valid         (if_valid),
        .if_pc            (if_pc),
        .if_inst          (if_inst),
        .if_predict       (if_predict),
        .stall            (stall),
        .ex_rs1_data      (ex_rs1_data),
        .ex_rs2_data      (ex_rs2_data),
`ifdef BRU_STATS_EN
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts),
`endif
        .b_check          (b_check),
        .b_take           (b_take),
        .flush            (flush),
        .redirect_pc      (redirect_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] enc_b(input logic [2:0] f3,
                                          input logic [12:0] imm);
        return {imm[12], imm[10:5], 5'd2, 5'd1, f3,
                imm[4:1], imm[11], 7'b1100011};
    endfunction

    // Outcome from the ISA rules, no knowledge of DUT internals.
    task automatic ref_eval(input rec_t r, input logic [31:0] a,
                            input logic [31:0] b, output bit chk_o,
                            output bit tk, output bit fl,
                            output logic [31:0] rpc);
        int f3;
        int imm;
        bit c;
        f3  = int'(r.inst[14:12]);
        c   = 1'b0;
        case (f3)
            0: c = (a == b);
            1: c = (a != b);
            4: c = ($signed(a) < $signed(b));
            5: c = ($signed(a) >= $signed(b));
            6: c = (a < b);
            7: c = (a >= b);
            default: c = 1'b0;
        endcase
        chk_o = r.v && (r.inst[6:0] == 7'h63) && f3 != 2 && f3 != 3;
        tk    = chk_o && c;
        fl    = chk_o && (tk != r.p);
        imm   = (r.inst[31] ? -4096 : 0) + int'(r.inst[7]) * 2048
              + int'(r.inst[30:25]) * 32 + int'(r.inst[11:8]) * 2;
        if (!fl)
            rpc = 32'h0;
        else if (tk)
            rpc = r.pc + imm;
        else
            rpc = r.pc + 32'd4;
    endtask

    task automatic idle_inputs();
        if_valid    = 1'b0;
        if_pc       = 32'h0;
        if_inst     = 32'h0;
        if_predict  = 1'b0;
        stall       = 1'b0;
        ex_rs1_data = 32'h0;
        ex_rs2_data = 32'h0;
    endtask

    // Sample one instruction in IF and walk it into EX (inputs then quiet).
    task automatic issue(input logic [31:0] pc, input logic [31:0] inst,
                         input logic pred, input logic [31:0] a,
                         input logic [31:0] b);
        @(negedge clk);
        if_valid   = 1'b1;
        if_pc      = pc;
        if_inst    = inst;
        if_predict = pred;
        @(negedge clk);
        if_valid   = 1'b0;
        @(negedge clk);
        ex_rs1_data = a;
        ex_rs2_data = b;
        #1;
    endtask

    initial begin
        bit          e_chk;
        bit          e_tk;
        bit          e_fl;
        logic [31:0] e_rpc;
        rec_t        nr;
        rec_t        bub;

        idle_inputs();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_b_check", 32'(b_check), 32'h0);
        chk("rst_b_take", 32'(b_take), 32'h0);
        chk("rst_flush", 32'(flush), 32'h0);
        chk("rst_redirect", redirect_pc, 32'h0);
        @(negedge clk);
        rst = 1'b1;

        // BEQ, correctly predicted not-taken
        issue(32'h100, enc_b(3'b000, 13'h10), 1'b0, 32'd5, 32'd6);
        chk("beq_check", 32'(b_check), 32'h1);
        chk("beq_take", 32'(b_take), 32'h0);
        chk("beq_flush", 32'(flush), 32'h0);

        // BNE taken, predicted not-taken
        issue(32'h200, enc_b(3'b001, 13'h40), 1'b0, 32'd1, 32'd2);
        chk("bne_take", 32'(b_take), 32'h1);
        chk("bne_flush", 32'(flush), 32'h1);
        chk("bne_redirect", redirect_pc, 32'h240);
        @(negedge clk);
        #1;
        chk("bne_after_check", 32'(b_check), 32'h0);

        // BLT signed: 1 < -1 is false, predicted taken
        issue(32'h300, enc_b(3'b100, 13'h20), 1'b1, 32'h1, 32'hFFFF_FFFF);
        chk("blt_take", 32'(b_take), 32'h0);
        chk("blt_flush", 32'(flush), 32'h1);
        chk("blt_redirect", redirect_pc, 32'h304);
        issue(32'h300, enc_b(3'b110, 13'h20), 1'b1, 32'h1, 32'hFFFF_FFFF);
        chk("bltu_take", 32'(b_take), 32'h1);
        chk("bltu_flush", 32'(flush), 32'h0);
        chk("bltu_redirect", redirect_pc, 32'h0);

        // funct3 010 is not a branch
        issue(32'h380, enc_b(3'b010, 13'h20), 1'b1, 32'h1, 32'h1);
        chk("f3_010_check", 32'(b_check), 32'h0);
        chk("f3_010_flush", 32'(flush), 32'h0);

        // Negative offset wraps below zero
        issue(32'h8, enc_b(3'b000, 13'h1FF0), 1'b0, 32'h7, 32'h7);
        chk("wrap_redirect", redirect_pc, 32'hFFFF_FFF8);

        // Branch held in ID for two stall cycles
        @(negedge clk);
        if_valid    = 1'b1;
        if_pc       = 32'h400;
        if_inst     = enc_b(3'b000, 13'h8);
        if_predict  = 1'b1;
        ex_rs1_data = 32'd7;
        ex_rs2_data = 32'd7;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if_valid = 1'b0;
            stall    = (i < 2);
            #1;
            chk($sformatf("stall_bubble%0d", i), 32'(b_check), 32'h0);
        end
        @(negedge clk);
        #1;
        chk("stall_pulse", 32'(b_check), 32'h1);
        chk("stall_pulse_flush", 32'(flush), 32'h0);
        @(negedge clk);
        #1;
        chk("stall_single", 32'(b_check), 32'h0);

        // Flush while stalled: held ID branch must still be killed
        @(negedge clk);
        if_valid   = 1'b1;
        if_pc      = 32'h500;
        if_inst    = enc_b(3'b001, 13'h40);
        if_predict = 1'b0;
        @(negedge clk);
        if_pc      = 32'h504;
        if_inst    = enc_b(3'b000, 13'h8);
        if_predict = 1'b0;
        @(negedge clk);
        if_valid    = 1'b0;
        stall       = 1'b1;
        ex_rs1_data = 32'd1;
        ex_rs2_data = 32'd2;
        #1;
        chk("sf_flush", 32'(flush), 32'h1);
        @(negedge clk);
        stall = 1'b0;
        #1;
        chk("sf_ex_clear", 32'(b_check), 32'h0);
        @(negedge clk);
        #1;
        chk("sf_id_clear", 32'(b_check), 32'h0);

        // Async reset while a mispredict sits in EX
        issue(32'h600, enc_b(3'b001, 13'h40), 1'b0, 32'd1, 32'd2);
        chk("ar_flush_before", 32'(flush), 32'h1);
        #1;
        rst = 1'b0;
        #1;
        chk("ar_flush", 32'(flush), 32'h0);
        chk("ar_check", 32'(b_check), 32'h0);
        chk("ar_take", 32'(b_take), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        if_valid   = 1'b1;
        if_pc      = 32'h700;
        if_inst    = enc_b(3'b000, 13'h8);
        if_predict = 1'b0;
        #1;
        chk("ar_quiet0", 32'(b_check), 32'h0);
        @(negedge clk);
        if_valid = 1'b0;
        #1;
        chk("ar_quiet1", 32'(b_check), 32'h0);
        @(negedge clk);
        #1;
        chk("ar_new_check", 32'(b_check), 32'h1);

`ifdef BRU_STATS_EN
        @(negedge clk);
        rst = 1'b0;
        #1;
        rst = 1'b1;
        chk("st_clear", stat_branches, 32'h0);
        issue(32'h100, enc_b(3'b000, 13'h10), 1'b0, 32'd5, 32'd6);
        issue(32'h200, enc_b(3'b001, 13'h40), 1'b0, 32'd1, 32'd2);
        issue(32'h300, enc_b(3'b101, 13'h40), 1'b1, 32'd9, 32'd2);
        @(negedge clk);
        chk("st_branches", stat_branches, 32'd3);
        chk("st_mispredicts", stat_mispredicts, 32'd1);
`endif

        // Randomized traffic against the queue model
        @(negedge clk);
        idle_inputs();
        rst = 1'b0;
        #1;
        rst = 1'b1;
        bub = '{v: 1'b0, pc: 32'h0, inst: 32'h0, p: 1'b0};
        pl.delete();
        pl.push_back(bub);
        pl.push_back(bub);
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if_valid   = ($urandom_range(0, 9) < 8);
            if_pc      = $urandom() & 32'hFFFF_FFFC;
            if ($urandom_range(0, 3) != 0)
                if_inst = {$urandom() & 32'hFFFF_FF80} | 32'h63;
            else
                if_inst = $urandom();
            if_predict  = $urandom_range(0, 1);
            stall       = ($urandom_range(0, 4) == 0);
            ex_rs1_data = $urandom();
            if ($urandom_range(0, 2) == 0)
                ex_rs2_data = ex_rs1_data;
            else if ($urandom_range(0, 1) == 0)
                ex_rs2_data = ex_rs1_data ^ 32'h8000_0000;
            else
                ex_rs2_data = $urandom();
            #1;
            ref_eval(pl[0], ex_rs1_data, ex_rs2_data,
                     e_chk, e_tk, e_fl, e_rpc);
            chk("rnd_check", 32'(b_check), 32'(e_chk));
            chk("rnd_take", 32'(b_take), 32'(e_tk));
            chk("rnd_flush", 32'(flush), 32'(e_fl));
            chk("rnd_redirect", redirect_pc, e_rpc);
            nr = '{v: if_valid, pc: if_pc, inst: if_inst, p: if_predict};
            @(posedge clk);
            if (e_fl) begin
                pl[0] = bub;
                pl[1] = bub;
            end else if (stall) begin
                pl[0] = bub;
            end else begin
                void'(pl.pop_front());
                pl.push_back(nr);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Resolves conditional branches in EX and returns the outcome to the IF-stage 2-bit predictor via b_check/b_take.
- Carries each fetched instruction's prediction bit through the ID and EX slots. In EX it evaluates the branch condition, compares the outcome with the prediction, and on mismatch raises flush plus a redirect PC.
- Sits beside the ID/EX pipeline registers of the 5-stage core; its output feeds the PC mux.

Parameters:
XLEN, 32, datapath/PC width

Ports:
clk  input  1  core clock, rising edge
rst  input  1  asynchronous active-low reset (0 = reset)
if_valid  input  1  IF holds a real instruction this cycle
if_pc  input  XLEN  PC of IF instruction
if_inst  input  32  IF instruction word
if_predict  input  1  predictor decision for if_inst (1 = taken)
stall  input  1  hazard stall: hold ID slot, bubble into EX
ex_rs1_data  input  XLEN  forwarded rs1 operand of EX instruction
ex_rs2_data  input  XLEN  forwarded rs2 operand of EX instruction
b_check  output  1  EX holds a valid conditional branch (to predictor)
b_take  output  1  actual branch outcome (to predictor)
flush  output  1  misprediction: kill IF and ID instructions
redirect_pc  output  XLEN  correct fetch PC, meaningful when flush=1

Behaviour:
- Two slots, ID and EX; each holds {valid, pc, inst, predict}.
- On rst=0 (async), both valid bits clear. With valid=0 all outputs are 0, so b_check, b_take, flush = 0 and redirect_pc = 0 throughout reset.
- Slot update on posedge clk, in priority order:
  - flush=1: ID.valid <= 0, EX.valid <= 0. Wrong-path instructions are dropped, and flush overrides stall.
  - stall=1: ID holds its contents; EX.valid <= 0 (bubble).
  - otherwise: ID <= IF inputs (valid = if_valid); EX <= ID.
- Latency: an instruction sampled in IF at cycle n resolves combinationally at cycle n+2 with no stalls, n+2+k with k stall cycles.
- Branch decode: inst[6:0] == 7'b1100011 and funct3 in {000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU}. funct3 010/011 is not a branch (b_check=0, no flush).
- Condition: equality and unsigned compares use XLEN-bit values; BLT/BGE compare as signed.
- Target = EX.pc + sign-extended B-immediate {inst[31] x20, inst[7], inst[30:25], inst[11:8], 0}, mod 2^XLEN (wraps silently).
- b_check = EX.valid & is_branch; b_take = b_check & cond.
- flush = b_check & (b_take != EX.predict).
- redirect_pc = b_take ? target : EX.pc + 4 when flush=1, else 0.
- Non-branch in EX with EX.predict=1 never flushes. The predictor only acts on branch opcodes, so this case cannot arise.
- b_check pulses exactly once per resolved branch; a stalled branch never double-reports because EX receives a bubble.
- All outputs are purely combinational from the EX slot and operands. No output is registered.

Optional Feature:
BRU_STATS_EN
- Defined: adds stat_branches and stat_mispredicts outputs (XLEN each). They count b_check and flush cycles respectively, saturate at all-ones, and clear on rst.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package bru_pkg holds:
  - OPC_BRANCH = 7'b1100011
  - funct3 constants F3_BEQ..F3_BGEU
  - bslot_t struct {valid, pc, inst, predict}
  - function b_imm(inst) returning the sign-extended B-immediate
- One sub-module, branch_cond_eval: combinational; funct3 and two operands in, {is_valid_f3, cond} out.
- Slot registers and flush logic live in the top module.

Test Plan:
- Correct not-taken: BEQ at pc=0x100, rs1=5, rs2=6, predict=0. At n+2: b_check=1, b_take=0, flush=0.
- Taken mispredict: BNE at 0x200, imm=+0x40, rs1=1, rs2=2, predict=0. At n+2: b_take=1, flush=1, redirect_pc=0x240. Next cycle the ID/EX slots are empty (b_check=0).
- Not-taken mispredict, signed compare: BLT at 0x300, rs1=0x00000001, rs2=0xFFFFFFFF, predict=1. b_take=0, flush=1, redirect_pc=0x304. The same operands with BLTU give b_take=1, flush=0.
- Stall interaction: branch in ID with stall=1 for 2 cycles. EX shows bubbles (b_check=0) during the stall; the branch reaches EX at n+4 with exactly one b_check pulse. Assert stall and flush together: both slots clear.
- Reset mid-operation: drive rst=0 asynchronously while a mispredicted branch is in EX. flush, b_check and b_take drop to 0 immediately; after rst=1 there are no outputs until a new instruction traverses 2 cycles.
- BRU_STATS_EN: 3 branches with 1 mispredict give stat_branches=3, stat_mispredicts=1. A counter preloaded near all-ones saturates at 0xFFFFFFFF.
